// File: rtl/cprv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cprv_pkg
// Description : Shared definitions for the cprv load/store unit: opcodes,
//               funct3 encodings, LSU state type and access-size helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cprv_pkg;

    localparam logic [6:0] c_OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE = 7'b0100011;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LD  = 3'b011;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;
    localparam logic [2:0] c_F3_LWU = 3'b110;

    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;
    localparam logic [2:0] c_F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Byte-enable pattern for an access of 2**size_log2 bytes at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size_log2);
        logic [7:0] mask;
        case (size_log2)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    // Offset bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_low_mask(input logic [1:0] size_log2);
        logic [2:0] mask;
        case (size_log2)
            2'd0:    mask = 3'b000;
            2'd1:    mask = 3'b001;
            2'd2:    mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

    // log2 access size; undefined encodings collapse onto the doubleword form.
    function automatic logic [1:0] access_size(input logic is_store, input logic [2:0] funct3);
        logic [1:0] size_log2;
        if (is_store) begin
            size_log2 = funct3[2] ? 2'd3 : funct3[1:0];
        end else begin
            size_log2 = (funct3 == 3'b111) ? 2'd3 : funct3[1:0];
        end
        return size_log2;
    endfunction

    function automatic logic funct3_invalid(input logic is_store, input logic [2:0] funct3);
        return is_store ? funct3[2] : (funct3 == 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cprv_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : cprv_lsu_align
// Description : Combinational lane alignment for the LSU: store byte strobes
//               and lane-shifted store data, load extraction and extension.
// Revision    : 1.0 - initial release
// ============================================================================
module cprv_lsu_align
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [2:0]            i_offset,
    input  logic [DATA_WIDTH-1:0] i_store_data,
    input  logic [DATA_WIDTH-1:0] i_load_raw,
    output logic [STRB_WIDTH-1:0] o_store_strb,
    output logic [DATA_WIDTH-1:0] o_store_lane,
    output logic [DATA_WIDTH-1:0] o_load_data
);

    logic [5:0]            w_bit_shift;
    logic [7:0]            w_mask;
    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_bit_shift  = {i_offset, 3'b000};
    assign w_mask       = size_mask(i_size);
    assign o_store_strb = STRB_WIDTH'(w_mask) << i_offset;
    assign o_store_lane = i_store_data << w_bit_shift;
    assign w_shifted    = i_load_raw >> w_bit_shift;

    // Keep the accessed field at bit 0 and fill the upper bits per signedness.
    always_comb begin
        o_load_data = w_shifted;
        case (i_size)
            2'd0: o_load_data = {{(DATA_WIDTH-8){w_shifted[7] & ~i_unsigned}}, w_shifted[7:0]};
            2'd1: o_load_data = {{(DATA_WIDTH-16){w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
            2'd2: o_load_data = {{(DATA_WIDTH-32){w_shifted[31] & ~i_unsigned}}, w_shifted[31:0]};
            default: o_load_data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cprv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : cprv_lsu
// Description : RV64 load/store unit. Accepts one request at a time, issues a
//               single doubleword memory access and returns a one-cycle
//               writeback pulse. Optional misaligned/invalid-access trap is
//               enabled with the macro CPRV_LSU_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cprv_lsu
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 64,
    parameter int FUNCT3_WIDTH  = 3,
    parameter int REGADDR_WIDTH = 5,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_store,
    input  logic [FUNCT3_WIDTH-1:0]  req_funct3,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [REGADDR_WIDTH-1:0] req_rd,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic                     mem_we,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [STRB_WIDTH-1:0]    mem_wstrb,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     wb_valid,
    output logic                     wb_we,
    output logic [REGADDR_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     wb_fault
);

    lsu_state_t                 r_state;
    lsu_state_t                 w_next_state;
    logic                       r_store;
    logic [FUNCT3_WIDTH-1:0]    r_funct3;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic [REGADDR_WIDTH-1:0]   r_rd;
    logic [DATA_WIDTH-1:0]      r_wb_data;

    logic                       w_accept;
    logic [1:0]                 w_size;
    logic [2:0]                 w_offset;
    logic                       w_req_fault;
    logic                       r_fault;
    logic [STRB_WIDTH-1:0]      w_store_strb;
    logic [DATA_WIDTH-1:0]      w_store_lane;
    logic [DATA_WIDTH-1:0]      w_load_data;

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_size   = access_size(r_store, r_funct3);

`ifdef CPRV_LSU_MISALIGN_TRAP_EN
    logic [1:0] w_req_size;

    assign w_req_size  = access_size(req_store, req_funct3);
    assign w_req_fault = funct3_invalid(req_store, req_funct3)
                       | (|(req_addr[2:0] & align_low_mask(w_req_size)));
    // Only aligned requests reach memory, so the raw offset is already legal.
    assign w_offset    = r_addr[2:0];

    // Fault verdict travels with the request so DONE can report it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_fault <= w_req_fault;
        end
    end
`else
    assign w_req_fault = 1'b0;
    assign r_fault     = 1'b0;
    // Drop the misaligned low bits so the access stays inside its natural slot.
    assign w_offset    = r_addr[2:0] & ~align_low_mask(w_size);
`endif

    cprv_lsu_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_align (
        .i_size       (w_size),
        .i_unsigned   (r_funct3[2]),
        .i_offset     (w_offset),
        .i_store_data (r_wdata),
        .i_load_raw   (mem_rdata),
        .o_store_strb (w_store_strb),
        .o_store_lane (w_store_lane),
        .o_load_data  (w_load_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture and load result register; result clears on accept so
    // stores and faults report zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_store   <= 1'b0;
            r_funct3  <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_wb_data <= '0;
        end else if (w_accept) begin
            r_store   <= req_store;
            r_funct3  <= req_funct3;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_rd      <= req_rd;
            r_wb_data <= '0;
        end else if ((r_state == WAIT) && mem_rvalid) begin
            r_wb_data <= w_load_data;
        end
    end

    // Next-state and per-state outputs; everything idles at zero.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        mem_valid    = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wstrb    = '0;
        mem_wdata    = '0;
        wb_valid     = 1'b0;
        wb_we        = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        wb_fault     = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = w_req_fault ? DONE : REQ;
                end
            end
            REQ: begin
                mem_valid = 1'b1;
                mem_we    = r_store;
                mem_addr  = {r_addr[ADDR_WIDTH-1:3], 3'b000};
                if (r_store) begin
                    mem_wstrb = w_store_strb;
                    mem_wdata = w_store_lane;
                end
                if (mem_ready) begin
                    w_next_state = r_store ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                wb_valid     = 1'b1;
                wb_we        = ~r_store & ~r_fault;
                wb_rd        = r_rd;
                wb_data      = r_wb_data;
                wb_fault     = r_fault;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cprv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_cprv_lsu
// Description : Self-checking bench for cprv_lsu. A byte-level transaction
//               model predicts memory and writeback outputs; a monitor
//               compares them every cycle they are valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cprv_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_fault;

    cprv_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_fault   (wb_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_memv   = 0;

    // Model expectations for the transaction in flight.
    bit          mon_en = 1'b0;
    bit          exp_wb_ok = 1'b0;
    bit          exp_store;
    bit          exp_fault;
    logic [63:0] exp_mem_addr;
    logic [7:0]  exp_wstrb;
    logic [63:0] exp_wdata;
    logic [63:0] exp_wb_data;
    bit          exp_wb_we;
    logic [4:0]  exp_rd;

    logic [63:0] last_mem_addr, last_mem_wdata, last_wb_data;
    logic [7:0]  last_mem_wstrb;
    logic [4:0]  last_wb_rd;
    logic        last_wb_we, last_wb_fault;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Byte-level model: which bytes an access touches and what they carry.
    task automatic model_txn(input bit st, input logic [2:0] f3, input logic [63:0] a,
                             input logic [63:0] wd, input logic [4:0] rd, input logic [63:0] raw);
        int nb;
        int off;
        bit bad;
        bad = st ? f3[2] : (f3 == 3'b111);
        nb  = bad ? 8 : (1 << f3[1:0]);
        off = int'(a[2:0]);
`ifdef CPRV_LSU_MISALIGN_TRAP_EN
        exp_fault = bad || ((off % nb) != 0);
`else
        exp_fault = 1'b0;
        off = off - (off % nb);
`endif
        exp_mem_addr = a & ~64'd7;
        exp_wstrb    = 8'd0;
        exp_wdata    = 64'd0;
        exp_wb_data  = 64'd0;
        if (!exp_fault && st) begin
            for (int i = 0; i < nb; i++) begin
                exp_wstrb[off+i] = 1'b1;
                exp_wdata[(off+i)*8 +: 8] = wd[i*8 +: 8];
            end
        end else if (!exp_fault) begin
            for (int i = 0; i < nb; i++) exp_wb_data[i*8 +: 8] = raw[(off+i)*8 +: 8];
            if (!f3[2] && nb < 8 && exp_wb_data[nb*8-1])
                for (int i = nb*8; i < 64; i++) exp_wb_data[i] = 1'b1;
        end
        exp_wb_we = !st && !exp_fault;
        exp_rd    = rd;
        exp_store = st;
    endtask

    // Per-cycle compare against the model whenever outputs are meaningful.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (mem_valid) begin
                n_memv++;
                chk("mem_only_if_no_fault", {63'd0, mem_valid}, {63'd0, !exp_fault});
                chk("mem_addr", mem_addr, exp_mem_addr);
                chk("mem_we", {63'd0, mem_we}, {63'd0, exp_store});
                chk("mem_wstrb", {56'd0, mem_wstrb}, {56'd0, exp_wstrb});
                chk("mem_wdata", mem_wdata, exp_wdata);
                chk("req_ready_in_req", {63'd0, req_ready}, 64'd0);
                last_mem_addr  = mem_addr;
                last_mem_wstrb = mem_wstrb;
                last_mem_wdata = mem_wdata;
            end
            if (wb_valid) begin
                chk("wb_expected", {63'd0, exp_wb_ok}, 64'd1);
                chk("wb_we", {63'd0, wb_we}, {63'd0, exp_wb_we});
                chk("wb_rd", {59'd0, wb_rd}, {59'd0, exp_rd});
                chk("wb_data", wb_data, exp_wb_data);
                chk("wb_fault", {63'd0, wb_fault}, {63'd0, exp_fault});
                chk("req_ready_in_done", {63'd0, req_ready}, 64'd0);
                last_wb_data  = wb_data;
                last_wb_rd    = wb_rd;
                last_wb_we    = wb_we;
                last_wb_fault = wb_fault;
            end
        end
    end

    // Drive one request, act as memory, and check writeback timing.
    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input logic [4:0] rd,
                           input int stall, input int rdel, input logic [63:0] raw);
        int t0;
        int k;
        int w;
        int lat;
        bit hs;
        model_txn(st, f3, a, wd, rd, raw);
        step();
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        exp_wb_ok  = 1'b1;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        t0 = cyc;
        step();
        req_valid  = 1'b0;
        req_addr   = 64'hDEAD_0000_0000_0007;
        req_wdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        if (!exp_fault) begin
            hs = 1'b0;
            k  = 0;
            while (!hs && k < 40) begin
                if (mem_valid) begin
                    if (k < stall) mem_ready = 1'b0;
                    else begin
                        mem_ready = 1'b1;
                        hs = 1'b1;
                    end
                end
                step();
                k++;
            end
            mem_ready = 1'b0;
            chk("handshake_seen", {63'd0, hs}, 64'd1);
            if (!st) begin
                for (int j = 0; j < rdel; j++) step();
                mem_rvalid = 1'b1;
                mem_rdata  = raw;
                step();
                mem_rvalid = 1'b0;
                mem_rdata  = 64'hA5A5_A5A5_A5A5_A5A5;
            end
        end
        w = 0;
        while (!wb_valid && w < 40) begin
            step();
            w++;
        end
        lat = exp_fault ? 1 : (st ? 2 + stall : 3 + stall + rdel);
        chk("wb_latency", 64'(cyc - t0), 64'(lat));
        step();
        chk("wb_single_pulse", {63'd0, wb_valid}, 64'd0);
        exp_wb_ok = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_mem_we",    {63'd0, mem_we}, 64'd0);
        chk("rst_mem_addr",  mem_addr, 64'd0);
        chk("rst_mem_wstrb", {56'd0, mem_wstrb}, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_wb_valid",  {63'd0, wb_valid}, 64'd0);
        chk("rst_wb_we",     {63'd0, wb_we}, 64'd0);
        chk("rst_wb_rd",     {59'd0, wb_rd}, 64'd0);
        chk("rst_wb_data",   wb_data, 64'd0);
        chk("rst_wb_fault",  {63'd0, wb_fault}, 64'd0);
        mon_en = 1'b1;

        // SB into byte lane 3.
        run_txn(1'b1, 3'b000, 64'h1003, 64'h0000_0000_0000_00AB, 5'd1, 0, 0, 64'd0);
        chk("lit_sb_addr",  last_mem_addr, 64'h1000);
        chk("lit_sb_wstrb", {56'd0, last_mem_wstrb}, 64'h08);
        chk("lit_sb_wdata", last_mem_wdata, 64'h0000_0000_AB00_0000);
        chk("lit_sb_wb_we", {63'd0, last_wb_we}, 64'd0);

        // LH from the top halfword, negative.
        run_txn(1'b0, 3'b001, 64'h2006, 64'd0, 5'd7, 0, 0, 64'h8001_0000_0000_0000);
        chk("lit_lh_data", last_wb_data, 64'hFFFF_FFFF_FFFF_8001);
        chk("lit_lh_rd",   {59'd0, last_wb_rd}, 64'd7);
        chk("lit_lh_we",   {63'd0, last_wb_we}, 64'd1);

        // LWU zero-fills the upper word.
        run_txn(1'b0, 3'b110, 64'h2004, 64'd0, 5'd9, 0, 0, 64'h8000_0000_0000_0000);
        chk("lit_lwu_data", last_wb_data, 64'h0000_0000_8000_0000);

        // SD with memory stalling five cycles in REQ.
        run_txn(1'b1, 3'b011, 64'h4000, 64'h1122_3344_5566_7788, 5'd2, 5, 0, 64'd0);
        chk("lit_sd_wstrb", {56'd0, last_mem_wstrb}, 64'hFF);
        chk("lit_sd_wdata", last_mem_wdata, 64'h1122_3344_5566_7788);

        // Remaining sizes, signs and lanes.
        run_txn(1'b0, 3'b000, 64'h5005, 64'd0, 5'd3, 0, 0, 64'h0000_7F00_0000_0000);
        run_txn(1'b0, 3'b100, 64'h5001, 64'd0, 5'd4, 1, 0, 64'h0000_0000_0000_F000);
        run_txn(1'b0, 3'b010, 64'h6004, 64'd0, 5'd5, 0, 1, 64'hDEAD_BEEF_0000_0000);
        chk("lit_lw_data", last_wb_data, 64'hFFFF_FFFF_DEAD_BEEF);
        run_txn(1'b0, 3'b011, 64'h7000, 64'd0, 5'd31, 2, 2, 64'h0123_4567_89AB_CDEF);
        run_txn(1'b1, 3'b001, 64'h8006, 64'h0000_0000_0000_CAFE, 5'd6, 0, 0, 64'd0);
        chk("lit_sh_wstrb", {56'd0, last_mem_wstrb}, 64'hC0);
        run_txn(1'b1, 3'b010, 64'h8004, 64'h0000_0000_1234_5678, 5'd8, 0, 0, 64'd0);
        run_txn(1'b0, 3'b101, 64'h9002, 64'd0, 5'd10, 0, 0, 64'h0000_0000_ABCD_0000);
        chk("lit_lhu_data", last_wb_data, 64'h0000_0000_0000_ABCD);

        // Invalid encodings and a misaligned word.
        run_txn(1'b1, 3'b101, 64'hB000, 64'hCAFE_F00D_1234_5678, 5'd11, 0, 0, 64'd0);
        run_txn(1'b0, 3'b111, 64'hC000, 64'd0, 5'd12, 0, 0, 64'hFEDC_BA98_7654_3210);
        k_trap_block : begin
            int memv_before;
            memv_before = n_memv;
            run_txn(1'b0, 3'b010, 64'h3002, 64'd0, 5'd13, 0, 0, 64'h1122_3344_5566_7788);
`ifdef CPRV_LSU_MISALIGN_TRAP_EN
            chk("lit_trap_fault", {63'd0, last_wb_fault}, 64'd1);
            chk("lit_trap_data",  last_wb_data, 64'd0);
            chk("lit_trap_no_mem", 64'(n_memv - memv_before), 64'd0);
`else
            chk("lit_misalign_data", last_wb_data, 64'h0000_0000_5566_7788);
            chk("lit_misalign_fault", {63'd0, last_wb_fault}, 64'd0);
`endif
        end

        // Stray rvalid while idle must be ignored.
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        repeat (2) begin
            step();
            chk("idle_rvalid_ignored", {63'd0, wb_valid}, 64'd0);
        end

        // Reset while stalled in REQ.
        model_txn(1'b0, 3'b011, 64'hA000, 64'd0, 5'd14, 64'd0);
        exp_wb_ok  = 1'b0;
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b011;
        req_addr   = 64'hA000;
        step();
        req_valid  = 1'b0;
        step();
        chk("pre_rst_mem_valid", {63'd0, mem_valid}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_req_mem_valid_drop", {63'd0, mem_valid}, 64'd0);
        chk("rst_req_idle", {63'd0, req_ready}, 64'd1);
        step();
        rst = 1'b0;

        // Reset while waiting for read data; late rvalid must not write back.
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("wait_no_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("wait_not_ready", {63'd0, req_ready}, 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_wait_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_wait_idle", {63'd0, req_ready}, 64'd1);
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
        step();
        mem_rvalid = 1'b0;
        repeat (3) begin
            chk("rst_no_wb", {63'd0, wb_valid}, 64'd0);
            step();
        end

        // Unit still usable after the abandoned transactions.
        run_txn(1'b0, 3'b000, 64'hD007, 64'd0, 5'd15, 0, 0, 64'h8000_0000_0000_0000);
        chk("lit_post_rst_lb", last_wb_data, 64'hFFFF_FFFF_FFFF_FF80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/cprv_lsu.md
Name: cprv_lsu

Overview:
- Load/store unit for the RV64 core.
- Consumes the effective address the ALU produces for LOAD/STORE, along with funct3, store data and rd.
- Drives a single-outstanding, doubleword-wide data-memory interface.
- Aligns store data and byte strobes; extracts and sign/zero-extends load data; returns a one-cycle writeback result.

Parameters:
- DATA_WIDTH, 64, register and memory data width.
- ADDR_WIDTH, 64, address width.
- FUNCT3_WIDTH, 3, funct3 field width.
- REGADDR_WIDTH, 5, destination register index width.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request from execute stage
- req_ready  out  1  LSU can accept a request
- req_store  in  1  1 = STORE, 0 = LOAD
- req_funct3  in  FUNCT3_WIDTH  access size/sign
- req_addr  in  ADDR_WIDTH  effective address (ALU output)
- req_wdata  in  DATA_WIDTH  store data (rs2)
- req_rd  in  REGADDR_WIDTH  load destination
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_WIDTH  doubleword-aligned address
- mem_wstrb  out  STRB_WIDTH  byte enables
- mem_wdata  out  DATA_WIDTH  lane-aligned store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  read doubleword
- wb_valid  out  1  result valid, one-cycle pulse
- wb_we  out  1  register write required (loads only)
- wb_rd  out  REGADDR_WIDTH  destination register
- wb_data  out  DATA_WIDTH  extended load data
- wb_fault  out  1  access fault (see Optional Feature)

Behaviour:
- Reset: one clock; reset asynchronous, active-high. State IDLE. Outputs after reset: req_ready=1; mem_valid=0; mem_we=0; mem_addr=0; mem_wstrb=0; mem_wdata=0; wb_valid=0; wb_we=0; wb_rd=0; wb_data=0; wb_fault=0.
- Reset mid-operation abandons the transaction: mem_valid drops immediately; no wb_valid is produced.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch store flag, funct3, addr, wdata and rd; go to REQ.
- REQ:
  - mem_valid=1; mem_addr={addr[63:3],3'b0}; mem_we=store flag.
  - All memory outputs held stable until mem_ready.
  - On the handshake: store goes to DONE; load goes to WAIT.
- WAIT:
  - Wait for mem_rvalid; mem_rvalid outside WAIT is ignored.
  - On mem_rvalid, shift rdata right by addr[2:0]*8, extend per funct3, register into wb_data; go to DONE.
- DONE:
  - wb_valid=1 for exactly one cycle; wb_we=!store; wb_rd=latched rd.
  - For stores, wb_data=0.
  - Return to IDLE; req_ready=0 in this state, so there is no back-to-back accept.
- Latency from accept edge with zero-wait memory: store wb_valid at +2 cycles; load with rvalid the cycle after the handshake at +3 cycles.
- Load funct3 decoding: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. Signed forms replicate the top bit of the accessed field; unsigned forms zero-fill.
- Store funct3 decoding: 000 SB, 001 SH, 010 SW, 011 SD.
- Store strobes and data:
  - Size mask is 0x01, 0x03, 0x0F or 0xFF.
  - wstrb = mask << addr[2:0], truncated to 8 bits.
  - wdata = req_wdata << addr[2:0]*8.
  - Loads drive wstrb=0.
- Invalid funct3 (load 111, store 1xx): treated as LD/SD with wb_fault=0 unless the macro is defined.

Optional Feature:
- Macro: CPRV_LSU_MISALIGN_TRAP_EN.
- Defined:
  - A request is faulting if addr is not a multiple of the access size, or funct3 is invalid.
  - A faulting request goes IDLE→DONE with no memory request.
  - wb_valid=1, wb_fault=1, wb_we=0, wb_data=0.
- Undefined:
  - addr[2:0] is masked down to size alignment before strobe/shift.
  - wb_fault is tied to 0.

Decomposition:
- Package cprv_pkg holds:
  - LOAD/STORE opcode constants.
  - funct3 constants LB…LWU and SB…SD.
  - lsu_state_t enum {IDLE, REQ, WAIT, DONE}.
  - Size-mask function.
- One combinational sub-module, cprv_lsu_align: store strobe/data generation and load extraction/extension, shared by both paths.

Test Plan:
- SB, addr=0x1003, wdata=0xAB, mem_ready=1 → mem_addr=0x1000, wstrb=0x08, wdata=0x00000000AB000000, wb_valid at +2 cycles, wb_we=0.
- LH, addr=0x2006, rdata=0x8001_0000_0000_0000 → wb_data=0xFFFF_FFFF_FFFF_8001, wb_we=1, wb_rd=req_rd.
- LWU, addr=0x2004, rdata=0x8000_0000_0000_0000 → wb_data=0x0000_0000_8000_0000.
- mem_ready held low 5 cycles in REQ → mem_addr/wstrb/wdata stable, req_ready=0, no wb_valid until after the handshake.
- rst asserted while in WAIT → mem_valid=0 and state IDLE immediately; a later mem_rvalid produces no wb_valid.
- With CPRV_LSU_MISALIGN_TRAP_EN, LW at 0x3002 → no mem_valid, wb_valid at +1 cycle with wb_fault=1, wb_data=0.
